// File: rtl/axi_test_pkg.sv
// rtl/axi_test_pkg.sv - shared state type, AXI constants and helpers for axi_test_ctrl
package axi_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         PAT_MAX_W      = 512;

  // Beat data is the beat's own byte address replicated across the widest bus.
  function automatic logic [PAT_MAX_W-1:0] beat_pattern(input logic [31:0] addr);
    return {(PAT_MAX_W/32){addr}};
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/axi_test_ctrl_if.sv
// rtl/axi_test_ctrl_if.sv - AXI4 master bundle for axi_test_ctrl
// Read channels exist only when AXI_TEST_RDCHK_EN is defined.
interface axi_test_ctrl_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
`ifdef AXI_TEST_RDCHK_EN
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
`else
  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
`endif
endinterface

// File: rtl/axi_test_blen.sv
// rtl/axi_test_blen.sv - next INCR burst length: min(remaining, MAX_BURST, beats to 4KB edge)
module axi_test_blen #(
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 16,
  parameter int SIZE_W    = 32
) (
  input  logic [11:0]       addr_lo,
  input  logic [SIZE_W-1:0] remaining,
  output logic [8:0]        len
);
  localparam int LSB = $clog2(DATA_W/8);

  logic [12:0]       to_bnd;
  logic [SIZE_W-1:0] lim;

  always_comb begin
    to_bnd = (13'h1000 - {1'b0, addr_lo}) >> LSB;
    lim    = SIZE_W'(MAX_BURST);
    if (SIZE_W'(to_bnd) < lim) lim = SIZE_W'(to_bnd);
    if (remaining < lim) lim = remaining;
    len = 9'(lim);
  end
endmodule

// File: rtl/axi_test_ctrl.sv
// rtl/axi_test_ctrl.sv - bring-up AXI4 pattern writer with optional read-back check
// Define AXI_TEST_RDCHK_EN to add the read/compare phase after the write walk.
module axi_test_ctrl
  import axi_test_pkg::*;
#(
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 16,
  parameter int SIZE_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_en,
  input  logic [ADDR_W-1:0] test_addr,
  input  logic [SIZE_W-1:0] test_size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_cnt,
  axi_test_ctrl_if.master   m
);
  localparam int BEAT_B = DATA_W/8;
  localparam int LSB    = $clog2(BEAT_B);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [SIZE_W-1:0] remaining;
  logic [8:0]        burst_len, beat_cnt, next_len;
  logic [31:0]       beat_addr;
  logic [SIZE_W:0]   size_round;
  logic [SIZE_W-1:0] start_beats;
  logic [DATA_W-1:0] pat_data;
  logic              last_beat, aw_hs, w_hs, b_hs;
`ifdef AXI_TEST_RDCHK_EN
  logic [ADDR_W-1:0] base_addr;
  logic [SIZE_W-1:0] total_beats;
  logic              ar_hs, r_hs;
  logic [1:0]        err_inc;
`endif

  assign size_round  = {1'b0, test_size} + (SIZE_W+1)'(BEAT_B-1);
  assign start_beats = SIZE_W'(size_round >> LSB);
  assign pat_data    = DATA_W'(beat_pattern(beat_addr));
  assign last_beat   = (beat_cnt == burst_len - 9'd1);

  axi_test_blen #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .SIZE_W(SIZE_W)) u_blen (
    .addr_lo   (cur_addr[11:0]),
    .remaining (remaining),
    .len       (next_len)
  );

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign m.awvalid = (state == ST_AW);
  assign m.awaddr  = cur_addr;
  assign m.awlen   = 8'(next_len - 9'd1);
  assign m.awsize  = 3'(LSB);
  assign m.awburst = AXI_BURST_INCR;
  assign m.wvalid  = (state == ST_W);
  assign m.wdata   = pat_data;
  assign m.wstrb   = '1;
  assign m.wlast   = last_beat;
  assign m.bready  = (state == ST_B);
  assign aw_hs     = m.awvalid & m.awready;
  assign w_hs      = m.wvalid & m.wready;
  assign b_hs      = m.bready & m.bvalid;
`ifdef AXI_TEST_RDCHK_EN
  assign m.arvalid = (state == ST_AR);
  assign m.araddr  = cur_addr;
  assign m.arlen   = 8'(next_len - 9'd1);
  assign m.arsize  = 3'(LSB);
  assign m.arburst = AXI_BURST_INCR;
  assign m.rready  = (state == ST_R);
  assign ar_hs     = m.arvalid & m.arready;
  assign r_hs      = m.rready & m.rvalid;
  // Bad data/resp is one error per beat; a misplaced rlast adds one more.
  assign err_inc   = {1'b0, (m.rdata != pat_data) || (m.rresp != AXI_RESP_OKAY)}
                   + {1'b0, m.rlast != last_beat};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (test_en) state_nx = (start_beats == '0) ? ST_DONE : ST_AW;
      ST_AW:   if (aw_hs) state_nx = ST_W;
      ST_W:    if (w_hs && last_beat) state_nx = ST_B;
      ST_B: begin
        if (b_hs) begin
          if (remaining != '0) state_nx = ST_AW;
`ifdef AXI_TEST_RDCHK_EN
          else state_nx = ST_AR;
`else
          else state_nx = ST_DONE;
`endif
        end
      end
`ifdef AXI_TEST_RDCHK_EN
      ST_AR:   if (ar_hs) state_nx = ST_R;
      ST_R: begin
        if (r_hs && last_beat)
          state_nx = (remaining == SIZE_W'(burst_len)) ? ST_DONE : ST_AR;
      end
`endif
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr    <= '0;
      remaining   <= '0;
      burst_len   <= '0;
      beat_cnt    <= '0;
      beat_addr   <= '0;
      err         <= 1'b0;
      err_cnt     <= '0;
`ifdef AXI_TEST_RDCHK_EN
      base_addr   <= '0;
      total_beats <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (test_en) begin
            cur_addr    <= test_addr & ~ADDR_W'(BEAT_B-1);
            remaining   <= start_beats;
            err         <= 1'b0;
            err_cnt     <= '0;
`ifdef AXI_TEST_RDCHK_EN
            base_addr   <= test_addr & ~ADDR_W'(BEAT_B-1);
            total_beats <= start_beats;
`endif
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            burst_len <= next_len;
            beat_cnt  <= '0;
            beat_addr <= 32'(cur_addr);
          end
        end
        ST_W: begin
          if (w_hs) begin
            beat_cnt  <= beat_cnt + 9'd1;
            beat_addr <= beat_addr + 32'(BEAT_B);
            if (last_beat) begin
              cur_addr  <= cur_addr + (ADDR_W'(burst_len) << LSB);
              remaining <= remaining - SIZE_W'(burst_len);
            end
          end
        end
        ST_B: begin
          if (b_hs) begin
            if (m.bresp != AXI_RESP_OKAY) begin
              err     <= 1'b1;
              err_cnt <= sat_add16(err_cnt, 2'd1);
            end
`ifdef AXI_TEST_RDCHK_EN
            // Write walk finished: rewind to re-walk the same region for reads.
            if (remaining == '0) begin
              cur_addr  <= base_addr;
              remaining <= total_beats;
            end
`endif
          end
        end
`ifdef AXI_TEST_RDCHK_EN
        ST_AR: begin
          if (ar_hs) begin
            burst_len <= next_len;
            beat_cnt  <= '0;
            beat_addr <= 32'(cur_addr);
          end
        end
        ST_R: begin
          if (r_hs) begin
            beat_cnt  <= beat_cnt + 9'd1;
            beat_addr <= beat_addr + 32'(BEAT_B);
            if (err_inc != 2'd0) begin
              err     <= 1'b1;
              err_cnt <= sat_add16(err_cnt, err_inc);
            end
            if (last_beat) begin
              cur_addr  <= cur_addr + (ADDR_W'(burst_len) << LSB);
              remaining <= remaining - SIZE_W'(burst_len);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
